// File: rtl/tag_lookup_pkg.sv
// Shared definitions for the tag lookup controller: FSM state encoding,
// entry field positions for the default geometry and the stats counter width.
package tag_lookup_pkg;

  // Default RAM geometry; the controller overrides these through parameters.
  localparam int DEF_AWIDTH = 3;
  localparam int DEF_DWIDTH = 7;

  // Entry layout: {valid, tag}. The valid flag sits in the top bit.
  localparam int VALID_BIT = DEF_DWIDTH - 1;
  localparam int TAG_MSB   = DEF_DWIDTH - 2;
  localparam int TAG_LSB   = 0;

  // Width of the optional hit/miss counters.
  localparam int CNT_WIDTH = 16;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_COMPARE     = 2'd1;
  localparam state_t ST_REFILL_WAIT = 2'd2;
  localparam state_t ST_WRITE       = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter
  import tag_lookup_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear on demand.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Lookup controller in front of a synchronous-read tag RAM. A request's
// index goes to the RAM on the accept edge, the entry is compared the next
// cycle, and a miss is refilled by writing {1, tag} once fill_ack arrives.
// Optional hit/miss statistics are built when TAG_LOOKUP_STATS_EN is defined.
module tag_lookup_ctrl
  import tag_lookup_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 7
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DWIDTH-1+AWIDTH-1:0] req_addr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [AWIDTH-1:0]        resp_index,
  output logic                     fill_req,
  output logic [DWIDTH-2:0]        fill_tag,
  input  logic                     fill_ack,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DWIDTH-1:0]        ram_din,
  input  logic [DWIDTH-1:0]        ram_dout
`ifdef TAG_LOOKUP_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
`endif
);

  localparam int TWIDTH = DWIDTH - 1;

  state_t              state_reg;
  logic [TWIDTH-1:0]   tag_reg;
  logic [AWIDTH-1:0]   index_reg;
  logic                lookup_hit;

  // Handshake and RAM port are pure functions of state so the RAM sees the
  // incoming index on the same edge the request is accepted.
  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    ram_addr   = (state_reg == ST_IDLE) ? req_addr[AWIDTH-1:0] : index_reg;
    ram_we     = (state_reg == ST_WRITE);
    ram_din    = (state_reg == ST_WRITE) ? {1'b1, tag_reg} : '0;
    lookup_hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == tag_reg);
  end

  // Lookup FSM with registered response and refill outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      tag_reg    <= '0;
      index_reg  <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
      fill_req   <= 1'b0;
      fill_tag   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            tag_reg   <= req_addr[TWIDTH+AWIDTH-1:AWIDTH];
            index_reg <= req_addr[AWIDTH-1:0];
            state_reg <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (lookup_hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_index <= index_reg;
            state_reg  <= ST_IDLE;
          end else begin
            fill_req  <= 1'b1;
            fill_tag  <= tag_reg;
            state_reg <= ST_REFILL_WAIT;
          end
        end
        ST_REFILL_WAIT: begin
          if (fill_ack) begin
            fill_req  <= 1'b0;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_index <= index_reg;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef TAG_LOOKUP_STATS_EN
  // Completed lookups are tallied from the response pulse.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (stats_clr),
    .inc     (resp_valid & resp_hit),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (stats_clr),
    .inc     (resp_valid & ~resp_hit),
    .count   (miss_count)
  );
`endif

endmodule
